bp_update_ctrl: RTL

BP_UPDATE_CTRL -- requirements
Module: bp_update_ctrl

---
 rtl/bp_update_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/bp_update_ctrl.sv
// Branch-predictor update controller.
// Resolved branches from EX are queued (optionally only mispredicts) and
// replayed to the predictor as update strobes. After reset or a clear
// request, the controller sweeps every predictor entry with a clear strobe.
module bp_update_ctrl #(
  parameter int DEPTH          = 4,
  parameter int ENTRIES        = 32,
  parameter int FILTER_CORRECT = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   clear,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [31:0]                            in_pc,
  input  logic [31:0]                            in_target,
  input  logic                                   in_mispredict,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [31:0]                            out_pc,
  output logic [31:0]                            out_target,
  output logic                                   out_wrong,
  output logic                                   init_en,
  output logic [((ENTRIES > 1) ? $clog2(ENTRIES) : 1)-1:0] init_idx,
  output logic                                   busy,
  output logic [7:0]                             drop_cnt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [IW-1:0] LAST_IDX_C = IW'(ENTRIES - 1);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   init_idx_q, init_idx_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [7:0]      drop_cnt_q, drop_cnt_d;

  // Payload storage: {pc, target, mispredict}
  logic [64:0]     fifo_mem [DEPTH];
  logic [64:0]     head;

  logic            push;
  logic            pop;

  // Outputs decode registered state only; rst forces the idle/busy values.
  always_comb begin
    in_ready  = !rst && (state_q == ST_RUN) && (count_q < DEPTH_C);
    out_valid = !rst && (state_q == ST_RUN) && (count_q != '0);
    init_en   = !rst && (state_q == ST_INIT);
    busy      = rst || (state_q != ST_RUN) || (count_q != '0);
    init_idx  = init_idx_q;
    drop_cnt  = drop_cnt_q;
    head       = fifo_mem[rd_ptr_q];
    out_pc     = head[64:33];
    out_target = head[32:1];
    out_wrong  = head[0];
  end

  // Handshake qualifiers; a clear in the same cycle cancels both.
  always_comb begin
    push = in_valid && in_ready && !clear &&
           ((FILTER_CORRECT == 0) || in_mispredict);
    pop  = out_valid && out_ready && !clear;
  end

  // Next-state: sweep sequencing, flush, queue pointers and drop counter.
  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    drop_cnt_d = drop_cnt_q;

    case (state_q)
      ST_INIT: begin
        if (clear) begin
          init_idx_d = '0;
        end else if (init_idx_q == LAST_IDX_C) begin
          state_d    = ST_RUN;
          init_idx_d = '0;
        end else begin
          init_idx_d = init_idx_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (clear) begin
          state_d  = ST_FLUSH;
          count_d  = '0;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
        end else begin
          if (push) wr_ptr_d = wr_ptr_q + 1'b1;
          if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
          case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
          endcase
        end
      end
      ST_FLUSH: begin
        state_d    = ST_INIT;
        init_idx_d = '0;
      end
      default: begin
        state_d    = ST_INIT;
        init_idx_d = '0;
      end
    endcase

    if (in_valid && !in_ready && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      init_idx_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Queue write port; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {in_pc, in_target, in_mispredict};
    end
  end

endmodule
